// File: rtl/draw_pkg.sv
// Shared widths, screen geometry and FSM state encoding for the draw arbiter.
package draw_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COL_W    = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DRAW   = 2'd3
  } state_t;

endpackage

// File: rtl/draw_arbiter_rr_picker.sv
// Round-robin picker: first requesting index at or above ptr, wrapping at NUM_SRC.
module rr_picker #(
  parameter int NUM_SRC = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               found,
  output logic [PTR_W-1:0]   idx
);

  // Scan offsets 0..NUM_SRC-1 from ptr; the first hit is held by the found flag.
  always_comb begin
    int              sum_s;
    logic [PTR_W-1:0] cand_s;
    logic            hit_s;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sum_s  = int'(ptr) + k;
      cand_s = (sum_s >= NUM_SRC) ? PTR_W'(sum_s - NUM_SRC) : PTR_W'(sum_s);
      hit_s  = ~found & req[cand_s];
      idx    = hit_s ? cand_s : idx;
      found  = found | hit_s;
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Grants the framebuffer to one drawing engine at a time and forwards its pixel stream to the VGA adapter.
module draw_arbiter
  import draw_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int START_LAT = 2,
  parameter int TIMEOUT   = 32768
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_SRC-1:0]       src_req,
  input  logic [X_W*NUM_SRC-1:0]   src_x,
  input  logic [Y_W*NUM_SRC-1:0]   src_y,
  input  logic [COL_W*NUM_SRC-1:0] src_col,
  input  logic [NUM_SRC-1:0]       src_done,
  output logic [NUM_SRC-1:0]       src_start,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COL_W-1:0]         vga_colour,
  output logic                     vga_plot,
  output logic                     busy,
  output logic [2:0]               owner,
  output logic                     timeout_err
);

  localparam int PTR_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(START_LAT - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_r;
  logic [PTR_W-1:0]   owner_r;
  logic [PTR_W-1:0]   rr_ptr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               pick_found_s;
  logic [PTR_W-1:0]   pick_idx_s;
  logic [PTR_W-1:0]   next_ptr_s;
  logic [X_W-1:0]     sel_x_s;
  logic [Y_W-1:0]     sel_y_s;
  logic [COL_W-1:0]   sel_col_s;
  logic               sel_done_s;

  rr_picker #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req   (src_req),
    .ptr   (rr_ptr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  assign sel_x_s    = src_x[int'(owner_r)*X_W +: X_W];
  assign sel_y_s    = src_y[int'(owner_r)*Y_W +: Y_W];
  assign sel_col_s  = src_col[int'(owner_r)*COL_W +: COL_W];
  assign sel_done_s = src_done[owner_r];
  // After a grant the pointer moves past the owner so it queues behind everyone else.
  assign next_ptr_s = (owner_r == PTR_W'(NUM_SRC - 1)) ? '0 : owner_r + PTR_W'(1);
  assign owner      = 3'(owner_r);

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      owner_r     <= '0;
      rr_ptr_r    <= '0;
      cnt_r       <= '0;
      src_start   <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      src_start   <= '0;
      timeout_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            owner_r   <= pick_idx_s;
            src_start <= {{(NUM_SRC-1){1'b0}}, 1'b1} << pick_idx_s;
            busy      <= 1'b1;
            state_r   <= ST_START;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          cnt_r   <= '0;
          state_r <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // The last settle cycle already carries the engine's first pixel.
          if (cnt_r == LAT_LAST) begin
            cnt_r      <= '0;
            vga_x      <= sel_x_s;
            vga_y      <= sel_y_s;
            vga_colour <= sel_col_s;
            vga_plot   <= 1'b1;
            state_r    <= ST_DRAW;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DRAW: begin
          vga_x      <= sel_x_s;
          vga_y      <= sel_y_s;
          vga_colour <= sel_col_s;
          if (sel_done_s) begin
            vga_plot <= 1'b0;
            rr_ptr_r <= next_ptr_s;
            cnt_r    <= '0;
            busy     <= 1'b0;
            state_r  <= ST_IDLE;
          end else if (cnt_r == TMO_LAST) begin
            vga_plot    <= 1'b0;
            timeout_err <= 1'b1;
            rr_ptr_r    <= next_ptr_s;
            cnt_r       <= '0;
            busy        <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            vga_plot <= 1'b1;
            cnt_r    <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          vga_plot <= 1'b0;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
